// File: rtl/uart_rx_deserializer_if.sv
// Receive-side bundle between the UART RX deserializer and its environment:
// serial line and FIFO-full input, FIFO write port and error pulses out.
interface uart_rx_deserializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  rx;
    logic                  fifo_full;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  frame_err;
    logic                  parity_err;
    logic                  overrun;
    logic                  busy;

    // Environment side: drives the line and FIFO status, observes the results.
    modport master (
        output rx,
        output fifo_full,
        input  wr_en,
        input  wr_data,
        input  frame_err,
        input  parity_err,
        input  overrun,
        input  busy
    );

    // Deserializer side.
    modport slave (
        input  rx,
        input  fifo_full,
        output wr_en,
        output wr_data,
        output frame_err,
        output parity_err,
        output overrun,
        output busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronizes rx, deserializes LSB-first characters,
// checks optional parity and the stop bit, and writes good characters to the RX FIFO.
module uart_rx_deserializer #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input logic                    clk,
    input logic                    rst,
    uart_rx_deserializer_if.slave  rx_bus
);

    localparam int unsigned CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_WIDTH - 1);
    localparam logic            OddBit   = (PARITY_ODD != 0);
    localparam logic            ParOn    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        StWaitIdle,
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [1:0]            sync_vld_q;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_bad_q, par_bad_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  frame_err_q, frame_err_d;
    logic                  parity_err_q, parity_err_d;
    logic                  overrun_q, overrun_d;
    logic                  busy_q;

    // The synchronizer presets to 1 on reset; sync_vld_q keeps WAIT_IDLE from
    // mistaking that preset for an idle line before real samples have arrived.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            sync_vld_q <= 2'b00;
        end else begin
            rx_meta_q  <= rx_bus.rx;
            rx_s_q     <= rx_meta_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StWaitIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= (state_d != StIdle);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;

        unique case (state_q)
            StWaitIdle: begin
                cnt_d = '0;
                if (sync_vld_q[1] && rx_s_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d   = StStart;
                    par_bad_d = 1'b0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                    idx_d   = idx_q + IdxW'(1);
                    if (idx_q == IdxLast) begin
                        state_d = ParOn ? StParity : StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StParity: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    par_bad_d = ((^shift_q) ^ rx_s_q) != OddBit;
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitIdle;
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = StIdle;
                    end else if (rx_bus.fifo_full) begin
                        overrun_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = shift_q;
                        state_d   = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StWaitIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_bus.wr_en      = wr_en_q;
    assign rx_bus.wr_data    = wr_data_q;
    assign rx_bus.frame_err  = frame_err_q;
    assign rx_bus.parity_err = parity_err_q;
    assign rx_bus.overrun    = overrun_q;
    assign rx_bus.busy       = busy_q;

endmodule
